// File: rtl/pipeline_sequencer_pkg.sv
// Shared types and constants for the pipeline stall/flush sequencer.
// Holds the state encoding, the control-bundle struct and the source-match helper.
package pipeline_sequencer_pkg;

    localparam int REG_ADDR_W = 4;
    localparam int STATE_W    = 2;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;

    typedef enum logic [STATE_W-1:0] {
        PS_RUN      = 2'd0,
        PS_MEM_WAIT = 2'd1,
        PS_SHADOW   = 2'd2
    } pipe_state_e;

    typedef struct packed {
        logic pc_freeze;
        logic if_freeze;
        logic if_flush;
        logic id_freeze;
        logic id_flush;
        logic exe_freeze;
        logic mem_freeze;
        logic wb_bubble;
    } pipe_ctrl_t;

    localparam pipe_ctrl_t CTRL_NONE = '0;

    // Whole pipeline held; the instruction leaving MEM must not write back twice.
    localparam pipe_ctrl_t CTRL_MEM_STALL = '{
        pc_freeze: 1'b1, if_freeze: 1'b1, if_flush: 1'b0, id_freeze: 1'b1,
        id_flush: 1'b0, exe_freeze: 1'b1, mem_freeze: 1'b1, wb_bubble: 1'b1
    };

    localparam pipe_ctrl_t CTRL_BRANCH_FLUSH = '{
        pc_freeze: 1'b0, if_freeze: 1'b0, if_flush: 1'b1, id_freeze: 1'b0,
        id_flush: 1'b1, exe_freeze: 1'b0, mem_freeze: 1'b0, wb_bubble: 1'b0
    };

    localparam pipe_ctrl_t CTRL_HAZARD_BUBBLE = '{
        pc_freeze: 1'b1, if_freeze: 1'b1, if_flush: 1'b0, id_freeze: 1'b0,
        id_flush: 1'b1, exe_freeze: 1'b0, mem_freeze: 1'b0, wb_bubble: 1'b0
    };

    function automatic logic src_match(
        input reg_addr_t src_1,
        input reg_addr_t src_2,
        input logic      src_valid,
        input logic      two_src,
        input reg_addr_t dest
    );
        return (src_valid && (src_1 == dest)) || (two_src && (src_2 == dest));
    endfunction

endpackage

// File: rtl/pipeline_sequencer_if.sv
// Bundle of hazard inputs, pipeline controls and counters between the datapath and the sequencer.
// The sequencer takes the slave side; the pipeline/datapath takes the master side.
interface pipeline_sequencer_if #(
    parameter int CNT_W = 16
);
    pipeline_sequencer_pkg::reg_addr_t src_1;
    pipeline_sequencer_pkg::reg_addr_t src_2;
    pipeline_sequencer_pkg::reg_addr_t exe_dest;
    pipeline_sequencer_pkg::reg_addr_t mem_dest;
    logic two_src;
    logic src_valid;
    logic exe_wb_en;
    logic exe_mem_r_en;
    logic mem_wb_en;
    logic forward_en;
    logic branch_taken;
    logic mem_access;
    logic mem_ready;

    logic pc_freeze;
    logic if_freeze;
    logic if_flush;
    logic id_freeze;
    logic id_flush;
    logic exe_freeze;
    logic mem_freeze;
    logic wb_bubble;
    logic hazard;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;
    logic mem_timeout;

    modport master (
        output src_1, src_2, exe_dest, mem_dest, two_src, src_valid, exe_wb_en,
               exe_mem_r_en, mem_wb_en, forward_en, branch_taken, mem_access, mem_ready,
        input  pc_freeze, if_freeze, if_flush, id_freeze, id_flush, exe_freeze,
               mem_freeze, wb_bubble, hazard, stall_cnt, flush_cnt, mem_timeout
    );

    modport slave (
        input  src_1, src_2, exe_dest, mem_dest, two_src, src_valid, exe_wb_en,
               exe_mem_r_en, mem_wb_en, forward_en, branch_taken, mem_access, mem_ready,
        output pc_freeze, if_freeze, if_flush, id_freeze, id_flush, exe_freeze,
               mem_freeze, wb_bubble, hazard, stall_cnt, flush_cnt, mem_timeout
    );

endinterface

// File: rtl/pipeline_sequencer_hazard_detect.sv
// Combinational RAW-hazard detector between the ID-stage sources and in-flight destinations.
// With forwarding enabled only a load in EXE cannot be bypassed in time.
module pipeline_sequencer_hazard_detect
    import pipeline_sequencer_pkg::*;
(
    input  reg_addr_t src_1,
    input  reg_addr_t src_2,
    input  logic      two_src,
    input  logic      src_valid,
    input  reg_addr_t exe_dest,
    input  logic      exe_wb_en,
    input  logic      exe_mem_r_en,
    input  reg_addr_t mem_dest,
    input  logic      mem_wb_en,
    input  logic      forward_en,
    output logic      hazard
);

    logic exe_match;
    logic mem_match;

    assign exe_match = src_match(src_1, src_2, src_valid, two_src, exe_dest);
    assign mem_match = src_match(src_1, src_2, src_valid, two_src, mem_dest);

    assign hazard = forward_en
                  ? (exe_wb_en && exe_mem_r_en && exe_match)
                  : ((exe_wb_en && exe_match) || (mem_wb_en && mem_match));

endmodule

// File: rtl/pipeline_sequencer.sv
// Stall/flush controller for the 5-stage pipeline: memory freeze, branch squash, RAW bubbles,
// plus saturating stall/flush counters and a sticky memory-timeout flag.
module pipeline_sequencer
    import pipeline_sequencer_pkg::*;
#(
    parameter int CNT_W       = 16,
    parameter int MEM_TIMEOUT = 64
) (
    input logic clk,
    input logic rst,
    pipeline_sequencer_if.slave bus
);

    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX  = WAIT_W'(MEM_TIMEOUT);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

    pipe_state_e       state;
    pipe_state_e       state_next;
    pipe_ctrl_t        ctrl;
    pipe_ctrl_t        ctrl_out;
    logic              hazard_raw;
    logic              mem_stall;
    logic              stall_inc;
    logic              flush_inc;
    logic              wait_inc;
    logic [WAIT_W-1:0] wait_cnt;
    logic [CNT_W-1:0]  stall_cnt;
    logic [CNT_W-1:0]  flush_cnt;
    logic              mem_timeout;

    pipeline_sequencer_hazard_detect u_hazard_detect (
        .src_1        (bus.src_1),
        .src_2        (bus.src_2),
        .two_src      (bus.two_src),
        .src_valid    (bus.src_valid),
        .exe_dest     (bus.exe_dest),
        .exe_wb_en    (bus.exe_wb_en),
        .exe_mem_r_en (bus.exe_mem_r_en),
        .mem_dest     (bus.mem_dest),
        .mem_wb_en    (bus.mem_wb_en),
        .forward_en   (bus.forward_en),
        .hazard       (hazard_raw)
    );

    // NOTE: every signal written here gets a default first so no path infers a latch.
    always_comb begin
        state_next = PS_RUN;
        ctrl       = CTRL_NONE;
        stall_inc  = 1'b0;
        flush_inc  = 1'b0;
        wait_inc   = 1'b0;

        // Once waiting, only mem_ready ends the stall; the access itself is frozen in MEM.
        mem_stall = (state == PS_MEM_WAIT) ? !bus.mem_ready
                                           : (bus.mem_access && !bus.mem_ready);

        if (mem_stall) begin
            ctrl       = CTRL_MEM_STALL;
            stall_inc  = 1'b1;
            wait_inc   = (state == PS_MEM_WAIT);
            state_next = PS_MEM_WAIT;
        end else if (bus.branch_taken) begin
            ctrl       = CTRL_BRANCH_FLUSH;
            flush_inc  = 1'b1;
            state_next = PS_SHADOW;
        end else if (hazard_raw && (state != PS_SHADOW)) begin
            ctrl      = CTRL_HAZARD_BUBBLE;
            stall_inc = 1'b1;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= PS_RUN;
            wait_cnt    <= '0;
            stall_cnt   <= '0;
            flush_cnt   <= '0;
            mem_timeout <= 1'b0;
        end else begin
            state <= state_next;

            if (!mem_stall) begin
                wait_cnt <= '0;
            end else if (wait_inc && (wait_cnt != WAIT_MAX)) begin
                wait_cnt <= wait_cnt + 1'b1;
            end

            if (wait_inc && (wait_cnt >= WAIT_LAST)) begin
                mem_timeout <= 1'b1;
            end

            if (stall_inc && (stall_cnt != {CNT_W{1'b1}})) begin
                stall_cnt <= stall_cnt + 1'b1;
            end

            if (flush_inc && (flush_cnt != {CNT_W{1'b1}})) begin
                flush_cnt <= flush_cnt + 1'b1;
            end
        end
    end

    assign ctrl_out = rst ? CTRL_NONE : ctrl;

    assign bus.pc_freeze   = ctrl_out.pc_freeze;
    assign bus.if_freeze   = ctrl_out.if_freeze;
    assign bus.if_flush    = ctrl_out.if_flush;
    assign bus.id_freeze   = ctrl_out.id_freeze;
    assign bus.id_flush    = ctrl_out.id_flush;
    assign bus.exe_freeze  = ctrl_out.exe_freeze;
    assign bus.mem_freeze  = ctrl_out.mem_freeze;
    assign bus.wb_bubble   = ctrl_out.wb_bubble;
    assign bus.hazard      = hazard_raw;
    assign bus.stall_cnt   = stall_cnt;
    assign bus.flush_cnt   = flush_cnt;
    assign bus.mem_timeout = mem_timeout;

endmodule

// File: tb/tb_pipeline_sequencer.sv
// Self-checking bench for pipeline_sequencer: directed scenarios plus randomized traffic
// compared against a behavioural model of the stall/flush rules.
module tb_pipeline_sequencer;
    import pipeline_sequencer_pkg::*;

    localparam int CNT_W       = 16;
    localparam int MEM_TIMEOUT = 8;
    localparam int CNT_MAX     = (1 << CNT_W) - 1;

    // Expected control vectors, bit order {pc_fz, if_fz, if_fl, id_fz, id_fl, exe_fz, mem_fz, wb_bub}.
    localparam logic [7:0] EXP_IDLE   = 8'h00;
    localparam logic [7:0] EXP_MEM    = 8'hD7;
    localparam logic [7:0] EXP_BRANCH = 8'h28;
    localparam logic [7:0] EXP_BUBBLE = 8'hC8;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    pipeline_sequencer_if #(.CNT_W(CNT_W)) bus ();

    pipeline_sequencer #(
        .CNT_W       (CNT_W),
        .MEM_TIMEOUT (MEM_TIMEOUT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Model: memory transaction outstanding, previous cycle flushed, counters and timeout.
    bit m_waiting     = 1'b0;
    bit m_shadow      = 1'b0;
    bit m_timeout     = 1'b0;
    int m_wait_cycles = 0;
    int m_stall       = 0;
    int m_flush       = 0;

    function automatic logic [7:0] dut_ctrl();
        return {bus.pc_freeze, bus.if_freeze, bus.if_flush, bus.id_freeze,
                bus.id_flush, bus.exe_freeze, bus.mem_freeze, bus.wb_bubble};
    endfunction

    function automatic bit model_hazard();
        reg_addr_t readers [2];
        bit        rd_live [2];
        reg_addr_t writers [2];
        bit        wr_live [2];
        readers = '{bus.src_1, bus.src_2};
        rd_live = '{bus.src_valid, bus.two_src};
        writers = '{bus.exe_dest, bus.mem_dest};
        if (bus.forward_en) wr_live = '{bus.exe_wb_en && bus.exe_mem_r_en, 1'b0};
        else                wr_live = '{bus.exe_wb_en, bus.mem_wb_en};
        for (int r = 0; r < 2; r++)
            for (int w = 0; w < 2; w++)
                if (rd_live[r] && wr_live[w] && readers[r] == writers[w]) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [7:0] model_ctrl();
        if (rst) return EXP_IDLE;
        if (!bus.mem_ready && (m_waiting || bus.mem_access)) return EXP_MEM;
        if (bus.branch_taken) return EXP_BRANCH;
        if (!m_shadow && model_hazard()) return EXP_BUBBLE;
        return EXP_IDLE;
    endfunction

    // Advance the model with the inputs present now, then let the clock edge pass.
    task automatic tick();
        logic [7:0] e;
        e = model_ctrl();
        if (rst) begin
            m_waiting = 0; m_shadow = 0; m_timeout = 0;
            m_wait_cycles = 0; m_stall = 0; m_flush = 0;
        end else if (e == EXP_MEM) begin
            if (m_stall < CNT_MAX) m_stall++;
            if (m_waiting) begin
                m_wait_cycles++;
                if (m_wait_cycles >= MEM_TIMEOUT) m_timeout = 1;
            end
            m_waiting = 1;
            m_shadow  = 0;
        end else begin
            m_waiting     = 0;
            m_wait_cycles = 0;
            if (e == EXP_BRANCH) begin
                if (m_flush < CNT_MAX) m_flush++;
                m_shadow = 1;
            end else begin
                if (e == EXP_BUBBLE && m_stall < CNT_MAX) m_stall++;
                m_shadow = 0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.src_1 = '0; bus.src_2 = '0; bus.exe_dest = '0; bus.mem_dest = '0;
        bus.two_src = 0; bus.src_valid = 0; bus.exe_wb_en = 0; bus.exe_mem_r_en = 0;
        bus.mem_wb_en = 0; bus.forward_en = 0; bus.branch_taken = 0;
        bus.mem_access = 0; bus.mem_ready = 0;
    endtask

    task automatic load_use();
        bus.forward_en = 1; bus.exe_dest = 4'd3; bus.exe_wb_en = 1;
        bus.exe_mem_r_en = 1; bus.src_1 = 4'd3; bus.src_valid = 1;
    endtask

    task automatic test_reset();
        idle();
        rst = 1;
        bus.mem_access = 1;
        bus.branch_taken = 1;
        #1;
        n_checks++;
        if (dut_ctrl() !== EXP_IDLE) begin
            n_fail++; $display("FAIL reset_ctrl: got %h want %h", dut_ctrl(), EXP_IDLE);
        end
        tick();
        tick();
        n_checks++;
        if (bus.stall_cnt !== '0 || bus.flush_cnt !== '0 || bus.mem_timeout !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: stall=%0d flush=%0d tmo=%b want 0/0/0",
                     bus.stall_cnt, bus.flush_cnt, bus.mem_timeout);
        end
        rst = 0;
        idle();
        #1;
        n_checks++;
        if (dut_ctrl() !== EXP_IDLE) begin
            n_fail++; $display("FAIL reset_release: got %h want %h", dut_ctrl(), EXP_IDLE);
        end
    endtask

    task automatic test_load_use();
        int s0;
        s0 = m_stall;
        idle();
        load_use();
        #1;
        n_checks++;
        if (bus.hazard !== 1'b1) begin
            n_fail++; $display("FAIL load_use_hazard: got %b want 1", bus.hazard);
        end
        n_checks++;
        if (dut_ctrl() !== EXP_BUBBLE) begin
            n_fail++; $display("FAIL load_use_ctrl: got %h want %h", dut_ctrl(), EXP_BUBBLE);
        end
        tick();
        idle();
        #1;
        n_checks++;
        if (bus.stall_cnt !== CNT_W'(s0 + 1)) begin
            n_fail++; $display("FAIL load_use_cnt: got %0d want %0d", bus.stall_cnt, s0 + 1);
        end
        n_checks++;
        if (dut_ctrl() !== EXP_IDLE) begin
            n_fail++; $display("FAIL load_use_after: got %h want %h", dut_ctrl(), EXP_IDLE);
        end
    endtask

    task automatic test_forwarding();
        int s0;
        idle();
        load_use();
        bus.exe_mem_r_en = 0;
        #1;
        n_checks++;
        if (dut_ctrl() !== EXP_IDLE || bus.hazard !== 1'b0) begin
            n_fail++; $display("FAIL fwd_alu: ctrl=%h hazard=%b want 00/0", dut_ctrl(), bus.hazard);
        end
        tick();
        s0 = m_stall;
        idle();
        bus.mem_dest = 4'd5; bus.mem_wb_en = 1; bus.two_src = 1; bus.src_2 = 4'd5;
        #1;
        n_checks++;
        if (dut_ctrl() !== EXP_BUBBLE) begin
            n_fail++; $display("FAIL nofwd_mem: got %h want %h", dut_ctrl(), EXP_BUBBLE);
        end
        tick();
        idle();
        #1;
        n_checks++;
        if (bus.stall_cnt !== CNT_W'(s0 + 1)) begin
            n_fail++; $display("FAIL nofwd_cnt: got %0d want %0d", bus.stall_cnt, s0 + 1);
        end
    endtask

    task automatic test_branch();
        int f0;
        f0 = m_flush;
        idle();
        bus.branch_taken = 1;
        #1;
        n_checks++;
        if (dut_ctrl() !== EXP_BRANCH) begin
            n_fail++; $display("FAIL branch_ctrl: got %h want %h", dut_ctrl(), EXP_BRANCH);
        end
        tick();
        idle();
        load_use();
        #1;
        n_checks++;
        if (bus.flush_cnt !== CNT_W'(f0 + 1)) begin
            n_fail++; $display("FAIL branch_cnt: got %0d want %0d", bus.flush_cnt, f0 + 1);
        end
        n_checks++;
        if (dut_ctrl() !== EXP_IDLE) begin
            n_fail++; $display("FAIL shadow_suppress: got %h want %h", dut_ctrl(), EXP_IDLE);
        end
        tick();
        n_checks++;
        if (dut_ctrl() !== EXP_BUBBLE) begin
            n_fail++; $display("FAIL after_shadow: got %h want %h", dut_ctrl(), EXP_BUBBLE);
        end
        tick();
        idle();
    endtask

    task automatic test_mem_wait();
        int s0;
        s0 = m_stall;
        idle();
        bus.mem_access = 1;
        for (int i = 0; i < 4; i++) begin
            #1;
            n_checks++;
            if (dut_ctrl() !== EXP_MEM) begin
                n_fail++; $display("FAIL mem_wait_%0d: got %h want %h", i, dut_ctrl(), EXP_MEM);
            end
            tick();
        end
        bus.mem_ready = 1;
        #1;
        n_checks++;
        if (dut_ctrl() !== EXP_IDLE) begin
            n_fail++; $display("FAIL mem_release: got %h want %h", dut_ctrl(), EXP_IDLE);
        end
        tick();
        idle();
        #1;
        n_checks++;
        if (bus.stall_cnt !== CNT_W'(s0 + 4)) begin
            n_fail++; $display("FAIL mem_stall_cnt: got %0d want %0d", bus.stall_cnt, s0 + 4);
        end
    endtask

    task automatic test_branch_in_wait();
        int f0;
        f0 = m_flush;
        idle();
        bus.mem_access = 1;
        bus.branch_taken = 1;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_checks++;
            if (dut_ctrl() !== EXP_MEM) begin
                n_fail++; $display("FAIL br_wait_%0d: got %h want %h", i, dut_ctrl(), EXP_MEM);
            end
            tick();
        end
        bus.mem_ready = 1;
        #1;
        n_checks++;
        if (dut_ctrl() !== EXP_BRANCH || bus.flush_cnt !== CNT_W'(f0)) begin
            n_fail++;
            $display("FAIL br_release: ctrl=%h flush=%0d want %h/%0d",
                     dut_ctrl(), bus.flush_cnt, EXP_BRANCH, f0);
        end
        tick();
        idle();
        #1;
        n_checks++;
        if (bus.flush_cnt !== CNT_W'(f0 + 1) || dut_ctrl() !== EXP_IDLE) begin
            n_fail++;
            $display("FAIL br_once: flush=%0d ctrl=%h want %0d/%h",
                     bus.flush_cnt, dut_ctrl(), f0 + 1, EXP_IDLE);
        end
        tick();
    endtask

    task automatic test_timeout();
        idle();
        bus.mem_access = 1;
        for (int i = 0; i < 10; i++) begin
            #1;
            n_checks++;
            // i cycles already frozen, i-1 of them spent waiting after the first.
            if (bus.mem_timeout !== (i >= MEM_TIMEOUT + 1) || dut_ctrl() !== EXP_MEM) begin
                n_fail++;
                $display("FAIL timeout_%0d: tmo=%b ctrl=%h want %b/%h",
                         i, bus.mem_timeout, dut_ctrl(), (i >= MEM_TIMEOUT + 1), EXP_MEM);
            end
            tick();
        end
        n_checks++;
        if (bus.mem_timeout !== 1'b1) begin
            n_fail++; $display("FAIL timeout_sticky: got %b want 1", bus.mem_timeout);
        end
        rst = 1;
        bus.mem_access = 0;
        #1;
        n_checks++;
        if (dut_ctrl() !== EXP_IDLE) begin
            n_fail++; $display("FAIL timeout_rst_ctrl: got %h want %h", dut_ctrl(), EXP_IDLE);
        end
        tick();
        rst = 0;
        #1;
        n_checks++;
        if (bus.stall_cnt !== '0 || bus.flush_cnt !== '0 || bus.mem_timeout !== 1'b0 ||
            dut_ctrl() !== EXP_IDLE) begin
            n_fail++;
            $display("FAIL timeout_rst_state: stall=%0d flush=%0d tmo=%b ctrl=%h want 0/0/0/00",
                     bus.stall_cnt, bus.flush_cnt, bus.mem_timeout, dut_ctrl());
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            rst              = ($urandom_range(0, 99) < 2);
            bus.src_1        = reg_addr_t'($urandom_range(0, 3));
            bus.src_2        = reg_addr_t'($urandom_range(0, 3));
            bus.exe_dest     = reg_addr_t'($urandom_range(0, 3));
            bus.mem_dest     = reg_addr_t'($urandom_range(0, 3));
            bus.two_src      = 1'($urandom_range(0, 1));
            bus.src_valid    = 1'($urandom_range(0, 1));
            bus.exe_wb_en    = 1'($urandom_range(0, 1));
            bus.exe_mem_r_en = 1'($urandom_range(0, 1));
            bus.mem_wb_en    = 1'($urandom_range(0, 1));
            bus.forward_en   = 1'($urandom_range(0, 1));
            bus.branch_taken = ($urandom_range(0, 99) < 15);
            bus.mem_access   = ($urandom_range(0, 99) < 30);
            bus.mem_ready    = ($urandom_range(0, 99) < 25);
            #1;
            n_checks++;
            if (dut_ctrl() !== model_ctrl()) begin
                n_fail++; $display("FAIL rnd_ctrl c%0d: got %h want %h", c, dut_ctrl(), model_ctrl());
            end
            n_checks++;
            if (bus.hazard !== model_hazard()) begin
                n_fail++; $display("FAIL rnd_hazard c%0d: got %b want %b", c, bus.hazard, model_hazard());
            end
            n_checks++;
            if (bus.stall_cnt !== CNT_W'(m_stall)) begin
                n_fail++; $display("FAIL rnd_stall c%0d: got %0d want %0d", c, bus.stall_cnt, m_stall);
            end
            n_checks++;
            if (bus.flush_cnt !== CNT_W'(m_flush)) begin
                n_fail++; $display("FAIL rnd_flush c%0d: got %0d want %0d", c, bus.flush_cnt, m_flush);
            end
            n_checks++;
            if (bus.mem_timeout !== m_timeout) begin
                n_fail++; $display("FAIL rnd_timeout c%0d: got %b want %b", c, bus.mem_timeout, m_timeout);
            end
            tick();
        end
        rst = 0;
        idle();
    endtask

    initial begin
        idle();
        test_reset();
        test_load_use();
        test_forwarding();
        test_branch();
        test_mem_wait();
        test_branch_in_wait();
        test_timeout();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
